gx4000_palette_fetch: RTL and testbench
=======================================

Name: gx4000_palette_fetch

Overview:
- Downstream consumer of the GX4000 ASIC block's ASIC RAM port.
- On each vsync rising edge it copies the 32-entry Plus palette from ASIC RAM page offset 0x2400–0x243F (CPU 0x6400–0x643F) into a local shadow register file.
- It serves registered 12-bit RGB lookups to the video output stage, plus a dedicated border colour.
- Fetching runs only while plus_mode and asic_valid are both high. Outside those conditions the shadow is frozen.

Parameters:
- BASE_ADDR, 14'h2400, ASIC RAM offset of palette entry 0 byte 0.
- NUM_ENTRIES, 32, palette entries; each entry is 2 bytes. Byte count = 2*NUM_ENTRIES.
- BORDER_IDX, 16, entry index driven on border_rgb.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- plus_mode  in  1  Plus features enabled.
- asic_valid  in  1  ASIC unlocked; comes from the ASIC block's asic_valid output.
- vsync  in  1  frame sync, level; the rising edge triggers a refresh.
- asic_ram_addr  out  14  ASIC RAM byte address.
- asic_ram_rd  out  1  read strobe. Data appears on asic_ram_q the following cycle.
- asic_ram_q  in  8  ASIC RAM read data, registered by the RAM owner.
- pen_sel  in  5  palette entry to look up.
- pen_req  in  1  lookup request.
- rgb_out  out  12  {R[3:0],G[3:0],B[3:0]} of the requested entry.
- rgb_valid  out  1  rgb_out valid; asserted 1 cycle after pen_req.
- border_rgb  out  12  shadow[BORDER_IDX], combinational from the shadow.
- busy  out  1  high while a fetch is in progress.
- frame_done  out  1  one-cycle pulse when a full 64-byte refresh completes.

Behaviour:
- Reset values:
  - All shadow entries = 12'h000.
  - asic_ram_addr = 0, asic_ram_rd = 0, rgb_out = 0, rgb_valid = 0, busy = 0, frame_done = 0.
  - pending = 0, state = IDLE, vsync_d = 0.
- Edge detect: vsync_d registers vsync every cycle. vs_rise = vsync & ~vsync_d.
- Enable: en = plus_mode & asic_valid.
- State machine: IDLE, FETCH, DRAIN.
  - IDLE: if en & (vs_rise | pending), clear pending, set issue_idx = 0, go to FETCH. busy = 1 from the next cycle.
  - FETCH: each cycle drive asic_ram_rd = 1 and asic_ram_addr = BASE_ADDR + issue_idx, then increment issue_idx. When issue_idx == 63 is issued, go to DRAIN.
  - DRAIN: one cycle to capture the final byte. Then pulse frame_done for 1 cycle, return to IDLE, busy = 0.
- Capture pipeline:
  - cap_valid and cap_idx are issue-valid and issue_idx delayed 1 cycle.
  - When cap_valid and cap_idx is even: store asic_ram_q in a low-byte holding register.
  - When cap_valid and cap_idx is odd: write entry cap_idx>>1 = {hold[7:4], asic_ram_q[3:0], hold[3:0]}. The low byte carries red in [7:4] and blue in [3:0]; the high byte carries green in [3:0].
  - Entries commit atomically, one per 2 bytes.
- Timing: a full refresh takes 64 issue cycles + 1 drain cycle. frame_done is asserted 65 cycles after the first asic_ram_rd.
- vs_rise during FETCH or DRAIN: set pending (1 deep). A new fetch starts the cycle after return to IDLE, if en still holds.
- Loss of enable mid-fetch (en falls in FETCH or DRAIN):
  - Abort to IDLE the next cycle; deassert asic_ram_rd.
  - No frame_done; pending is cleared.
  - Entries already committed remain. A half-received entry is discarded.
- Lookup:
  - When pen_req is high: rgb_out <= shadow[pen_sel] and rgb_valid <= 1. Otherwise rgb_valid <= 0 and rgb_out holds its value.
  - If a lookup hits an entry committing in the same cycle, it returns the old value; the new value is visible the next cycle.
  - Lookups work regardless of en.
- Outside FETCH, asic_ram_rd = 0 and asic_ram_addr holds its last value.
- Reset mid-fetch returns everything to reset values immediately, including the shadow.

Test Plan:
- Preload RAM 0x2400 = 8'hF0 and 0x2401 = 8'h0A; en = 1; pulse vsync → 64 consecutive reads at 0x2400..0x243F. Then frame_done pulses 65 cycles after the first read, and pen_sel = 0 returns rgb_out = 12'hFA0 one cycle later.
- Preload 0x2420 = 8'h5C and 0x2421 = 8'h03, refresh → border_rgb = 12'h53C.
- asic_valid = 0 with a vsync pulse → no asic_ram_rd, busy stays 0, shadow stays 12'h000.
- Second vsync edge at read 20 of a fetch → first fetch completes with frame_done, and the second fetch starts the next cycle, 64 reads again.
- plus_mode dropped after read 31 → reads stop, no frame_done. Entries 0–14 are updated and entry 15 onward is unchanged.
- Reset asserted during FETCH → busy = 0, asic_ram_rd = 0, all lookups return 12'h000.

Source files
------------

// File: rtl/gx4000_palette_fetch.sv
// GX4000 Plus palette shadow: on each vsync rising edge, copies the 32-entry palette out of
// ASIC RAM into a local register file. It also serves registered RGB lookups and a border colour.
module gx4000_palette_fetch #(
  parameter logic [13:0] BASE_ADDR   = 14'h2400,
  parameter int unsigned NUM_ENTRIES = 32,
  parameter int unsigned BORDER_IDX  = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        plus_mode,
  input  logic        asic_valid,
  input  logic        vsync,
  output logic [13:0] asic_ram_addr,
  output logic        asic_ram_rd,
  input  logic [7:0]  asic_ram_q,
  input  logic [4:0]  pen_sel,
  input  logic        pen_req,
  output logic [11:0] rgb_out,
  output logic        rgb_valid,
  output logic [11:0] border_rgb,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned     NumBytes = 2 * NUM_ENTRIES;
  localparam int unsigned     IdxW     = $clog2(NumBytes);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumBytes - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e          state_q, state_d;
  logic            vsync_q;
  logic            vs_rise;
  logic            en;
  logic            issue;
  logic            pending_q, pending_d;
  logic [IdxW-1:0] issue_idx_q, issue_idx_d;
  logic [13:0]     addr_q;
  logic            cap_valid_q;
  logic [IdxW-1:0] cap_idx_q;
  logic [7:0]      hold_q;
  logic            frame_done_q;
  logic [11:0]     rgb_q;
  logic            rgb_valid_q;
  logic [11:0]     shadow_q [NUM_ENTRIES];

  assign vs_rise = vsync & ~vsync_q;
  assign en      = plus_mode & asic_valid;

  // FSM state register
  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state; losing enable aborts straight back to idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en && (vs_rise || pending_q)) state_d = StFetch;
      StFetch: begin
        if (!en)                          state_d = StIdle;
        else if (issue_idx_q == LastIdx)  state_d = StDrain;
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; a read is only issued while enabled so an abort stops reads immediately
  always_comb begin
    issue         = (state_q == StFetch) && en;
    asic_ram_rd   = issue;
    asic_ram_addr = issue ? (BASE_ADDR + 14'(issue_idx_q)) : addr_q;
    busy          = (state_q != StIdle);
  end

  // Next values for the issue counter and the one-deep refresh request
  always_comb begin
    issue_idx_d = issue_idx_q;
    pending_d   = pending_q;
    if (state_q == StIdle) begin
      issue_idx_d = '0;
      if (en && (vs_rise || pending_q)) pending_d = 1'b0;
    end else begin
      if (issue)        issue_idx_d = issue_idx_q + IdxW'(1);
      if (!en)          pending_d = 1'b0;
      else if (vs_rise) pending_d = 1'b1;
    end
  end

  // Control registers: edge detect, counters, address hold, capture pipeline, done pulse
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vsync_q      <= 1'b0;
      pending_q    <= 1'b0;
      issue_idx_q  <= '0;
      addr_q       <= '0;
      cap_valid_q  <= 1'b0;
      cap_idx_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      vsync_q      <= vsync;
      pending_q    <= pending_d;
      issue_idx_q  <= issue_idx_d;
      addr_q       <= asic_ram_addr;
      cap_valid_q  <= issue;
      cap_idx_q    <= issue_idx_q;
      frame_done_q <= (state_q == StDrain) && en;
    end
  end

  // Byte capture: even byte parks in hold, odd byte commits the whole entry at once
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold_q <= '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) shadow_q[i] <= '0;
    end else if (cap_valid_q) begin
      if (!cap_idx_q[0]) begin
        hold_q <= asic_ram_q;
      end else begin
        shadow_q[cap_idx_q[IdxW-1:1]] <= {hold_q[7:4], asic_ram_q[3:0], hold_q[3:0]};
      end
    end
  end

  // Registered lookup; reads the pre-commit shadow so same-cycle writes return the old value
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      rgb_valid_q <= pen_req;
      if (pen_req) rgb_q <= shadow_q[pen_sel];
    end
  end

  assign rgb_out    = rgb_q;
  assign rgb_valid  = rgb_valid_q;
  assign frame_done = frame_done_q;
  assign border_rgb = shadow_q[BORDER_IDX];

endmodule

// File: tb/tb_gx4000_palette_fetch.sv
// Bench for gx4000_palette_fetch: behavioural ASIC RAM, read/done monitors, lookup scoreboard.
`timescale 1ns/1ps
module tb_gx4000_palette_fetch;

  logic        clk_sys = 1'b0;
  logic        reset, plus_mode, asic_valid, vsync;
  logic [13:0] asic_ram_addr;
  logic        asic_ram_rd;
  logic [7:0]  asic_ram_q;
  logic [4:0]  pen_sel;
  logic        pen_req;
  logic [11:0] rgb_out, border_rgb;
  logic        rgb_valid, busy, frame_done;

  logic [7:0]  mem [16384];
  logic [7:0]  lo_a [32];
  logic [7:0]  hi_a [32];
  logic [11:0] sh_a [32];
  logic [11:0] sh_b [32];
  logic [11:0] exp_q [$];

  int total = 0, bad = 0, cyc = 0;
  int rd_cnt = 0, addr_bad = 0, rd0_cyc = 0, rd64_cyc = 0;
  int fd_cnt = 0, fd0_cyc = 0, fd_last_cyc = 0, busy_cnt = 0;
  int snap;

  always #5 clk_sys = ~clk_sys;

  gx4000_palette_fetch dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .plus_mode     (plus_mode),
    .asic_valid    (asic_valid),
    .vsync         (vsync),
    .asic_ram_addr (asic_ram_addr),
    .asic_ram_rd   (asic_ram_rd),
    .asic_ram_q    (asic_ram_q),
    .pen_sel       (pen_sel),
    .pen_req       (pen_req),
    .rgb_out       (rgb_out),
    .rgb_valid     (rgb_valid),
    .border_rgb    (border_rgb),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  // ASIC RAM: data appears the cycle after the read strobe
  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (asic_ram_rd) asic_ram_q <= mem[asic_ram_addr];
  end

  // Read / done / busy monitor
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (asic_ram_rd) begin
        if (asic_ram_addr !== 14'h2400 + 14'(rd_cnt % 64)) addr_bad++;
        if (rd_cnt == 0)  rd0_cyc = cyc;
        if (rd_cnt == 64) rd64_cyc = cyc;
        rd_cnt++;
      end
      if (frame_done) begin
        if (fd_cnt == 0) fd0_cyc = cyc;
        fd_last_cyc = cyc;
        fd_cnt++;
      end
      if (busy) busy_cnt++;
    end
  end

  // Lookup scoreboard monitor
  always @(negedge clk_sys) begin
    logic [11:0] e;
    if (!reset && rgb_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL lookup_unexpected: got %h want no response", rgb_out);
      end else begin
        e = exp_q.pop_front();
        if (rgb_out !== e) begin
          bad++;
          $display("FAIL lookup: got %h want %h", rgb_out, e);
        end
      end
    end
  end

  function automatic logic [11:0] ent(input logic [7:0] lo, input logic [7:0] hi);
    return {lo[7:4], hi[3:0], lo[3:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  task automatic lookup(input logic [4:0] sel, input logic [11:0] e);
    pen_sel = sel;
    pen_req = 1'b1;
    exp_q.push_back(e);
    tick();
    pen_req = 1'b0;
  endtask

  task automatic wait_rd(input int n, input int budget);
    for (int i = 0; i < budget && rd_cnt < n; i++) tick();
  endtask

  task automatic wait_fd(input int n, input int budget);
    for (int i = 0; i < budget && fd_cnt < n; i++) tick();
  endtask

  task automatic clr_counts();
    rd_cnt = 0; addr_bad = 0; fd_cnt = 0; busy_cnt = 0;
  endtask

  task automatic load(input bit inv);
    for (int i = 0; i < 32; i++) begin
      mem[16'h2400 + 2*i]     = inv ? ~lo_a[i] : lo_a[i];
      mem[16'h2400 + 2*i + 1] = inv ? ~hi_a[i] : hi_a[i];
    end
  endtask

  initial begin
    reset = 1'b1; plus_mode = 1'b0; asic_valid = 1'b0; vsync = 1'b0;
    pen_sel = '0; pen_req = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) begin
      lo_a[i] = 8'(i * 37 + 11);
      hi_a[i] = 8'(i * 13 + 5);
    end
    lo_a[0] = 8'hF0;  hi_a[0] = 8'h0A;
    lo_a[16] = 8'h5C; hi_a[16] = 8'h03;
    for (int i = 0; i < 32; i++) begin
      sh_a[i] = ent(lo_a[i], hi_a[i]);
      sh_b[i] = ent(~lo_a[i], ~hi_a[i]);
    end

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_rd", asic_ram_rd, 0);
    check("rst_addr", asic_ram_addr, 0);
    check("rst_rgb", rgb_out, 0);
    check("rst_rgb_valid", rgb_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_border", border_rgb, 0);
    reset = 1'b0;
    tick();

    // ASIC locked: vsync must not fetch
    load(1'b0);
    plus_mode = 1'b1;
    clr_counts();
    pulse_vsync();
    repeat (10) tick();
    check("locked_reads", rd_cnt, 0);
    check("locked_busy", busy_cnt, 0);
    lookup(5'd0, 12'h000);
    check("locked_border", border_rgb, 12'h000);
    asic_valid = 1'b1;
    repeat (5) tick();
    check("locked_no_late_fetch", rd_cnt, 0);

    // Full refresh
    clr_counts();
    pulse_vsync();
    wait_rd(5, 20);
    check("t1_busy_mid", busy, 1);
    wait_fd(1, 200);
    check("t1_frame_done_cnt", fd_cnt, 1);
    check("t1_reads", rd_cnt, 64);
    check("t1_addr_seq", addr_bad, 0);
    check("t1_fd_latency", fd0_cyc - rd0_cyc, 65);
    lookup(5'd0, 12'hFA0);
    check("t1_busy_after", busy, 0);
    check("t1_border", border_rgb, 12'h53C);
    lookup(5'd5, sh_a[5]);
    lookup(5'd31, sh_a[31]);
    lookup(5'd16, 12'h53C);

    // Second vsync during fetch queues a back-to-back refresh
    clr_counts();
    pulse_vsync();
    wait_rd(20, 40);
    pulse_vsync();
    wait_fd(2, 400);
    check("pend_frame_done_cnt", fd_cnt, 2);
    check("pend_reads", rd_cnt, 128);
    check("pend_addr_seq", addr_bad, 0);
    check("pend_restart_gap", rd64_cyc - fd0_cyc, 1);
    check("pend_fd2_latency", fd_last_cyc - rd64_cyc, 65);
    repeat (5) tick();
    check("pend_no_third", rd_cnt, 128);

    // Drop plus_mode after 31 reads: entries 0..14 new, 15.. unchanged
    load(1'b1);
    clr_counts();
    pulse_vsync();
    wait_rd(31, 60);
    plus_mode = 1'b0;
    repeat (10) tick();
    check("abort_reads", rd_cnt, 31);
    check("abort_no_done", fd_cnt, 0);
    check("abort_busy", busy, 0);
    check("abort_addr_seq", addr_bad, 0);
    for (int i = 0; i < 32; i++) lookup(5'(i), (i < 15) ? sh_b[i] : sh_a[i]);
    check("abort_border", border_rgb, 12'h53C);
    plus_mode = 1'b1;
    repeat (5) tick();
    check("abort_no_restart", rd_cnt, 31);

    // Reset during fetch clears everything including the shadow
    clr_counts();
    pulse_vsync();
    wait_rd(10, 30);
    reset = 1'b1;
    tick();
    check("rstf_busy", busy, 0);
    check("rstf_rd", asic_ram_rd, 0);
    check("rstf_border", border_rgb, 12'h000);
    tick();
    reset = 1'b0;
    snap = rd_cnt;
    tick();
    lookup(5'd0, 12'h000);
    lookup(5'd15, 12'h000);
    lookup(5'd16, 12'h000);
    lookup(5'd31, 12'h000);
    repeat (5) tick();
    check("rstf_no_reads", rd_cnt, snap);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
